// File: rtl/board_io_pkg.sv
// Shared types, 50 MHz timing defaults and the count-width helper for board_io_ctrl.
package board_io_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } rst_state_e;

  localparam int DEF_DEB_CYCLES     = 500000;
  localparam int DEF_RST_HOLD       = 1024;
  localparam int DEF_STRETCH_CYCLES = 2500000;
  localparam int DEF_LONG_CYCLES    = 50000000;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release pulses.
// Long-press detection is built only when BOARD_IO_LONGPRESS_EN is defined.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int LONG_CYCLES    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          raw_in;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign raw_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = s2_q;
      press_d = s2_q;
      rel_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BOARD_IO_LONGPRESS_EN
  localparam int LW = cnt_width(LONG_CYCLES);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          armed_q, armed_d;
  logic          long_q, long_d;

  // Armed on the press edge; disarms after one pulse until the next press.
  always_comb begin
    lcnt_d  = lcnt_q;
    armed_d = armed_q;
    long_d  = 1'b0;
    if (!level_q) begin
      lcnt_d  = '0;
      armed_d = 1'b0;
    end else if (armed_q) begin
      if (lcnt_q == LW'(LONG_CYCLES - 1)) begin
        long_d  = 1'b1;
        armed_d = 1'b0;
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end
    if (press_d) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q  <= '0;
      armed_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      armed_q <= armed_d;
      long_q  <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/board_io_ctrl.sv
// ULX3S board I/O conditioning: button debounce, lock-gated reset sequencing, LED stretch.
// Optional long-press pulses on btn_long when BOARD_IO_LONGPRESS_EN is defined.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_BTN          = 2,
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int RST_HOLD       = DEF_RST_HOLD,
  parameter int N_LED          = 8,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int LONG_CYCLES    = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             sys_rst,
  input  logic [N_LED-1:0] led_evt,
  output logic [N_LED-1:0] led
);

  localparam int HW  = cnt_width(RST_HOLD);
  localparam int LCW = cnt_width(STRETCH_CYCLES);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW),
      .LONG_CYCLES   (LONG_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end

  logic          lock_s1_q, lock_s2_q;
  rst_state_e    state_q;
  logic [HW-1:0] hcnt_q;
  logic          sys_rst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  // Any loss of lock drops straight back to WAIT_LOCK so a relock re-runs the full hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      hcnt_q    <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          hcnt_q    <= '0;
          sys_rst_q <= 1'b1;
          if (lock_s2_q) state_q <= HOLD;
        end
        HOLD: begin
          sys_rst_q <= 1'b1;
          if (!lock_s2_q) begin
            state_q <= WAIT_LOCK;
            hcnt_q  <= '0;
          end else if (hcnt_q == HW'(RST_HOLD - 1)) begin
            state_q   <= RUN;
            hcnt_q    <= '0;
            sys_rst_q <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        RUN: begin
          hcnt_q <= '0;
          if (!lock_s2_q) begin
            state_q   <= WAIT_LOCK;
            sys_rst_q <= 1'b1;
          end else begin
            sys_rst_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= WAIT_LOCK;
          hcnt_q    <= '0;
          sys_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign sys_rst = sys_rst_q;

  logic [LCW-1:0] led_cnt_q [N_LED];
  logic [LCW-1:0] led_cnt_d [N_LED];
  logic [N_LED-1:0] led_q, led_d;

  // LED stays lit through the cycle where the counter reaches zero, giving STRETCH_CYCLES on-time.
  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    for (int i = 0; i < N_LED; i++) begin
      if (led_evt[i]) begin
        led_cnt_d[i] = LCW'(STRETCH_CYCLES - 1);
        led_d[i]     = 1'b1;
      end else if (led_cnt_q[i] != '0) begin
        led_cnt_d[i] = led_cnt_q[i] - LCW'(1);
      end else begin
        led_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LED; i++) led_cnt_q[i] <= '0;
      led_q <= '0;
    end else begin
      led_cnt_q <= led_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Board-level I/O conditioning block for the ULX3S top. It takes the raw buttons, the PLL lock flag and per-LED event strobes from the core, all in one clock domain (the 50 MHz system clock).
- Buttons: N-channel synchronisation and debouncing, with press/release edge pulses.
- Reset: lock-gated system reset sequencing.
- LEDs: retriggerable pulse stretching, so that single-cycle events are visible.

Parameters:
- N_BTN, 2: number of button channels.
- DEB_CYCLES, 500000: stable-input cycles required to accept a change (10 ms at 50 MHz); minimum 2.
- RST_HOLD, 1024: cycles sys_rst is held after the PLL lock is seen; minimum 1.
- N_LED, 8: number of LED channels.
- STRETCH_CYCLES, 2500000: minimum LED on-time per event; minimum 1.
- BTN_ACTIVE_LOW, 0: when 1, raw inputs are inverted before synchronisation.
- LONG_CYCLES, 50000000: long-press threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock; asynchronous, internally 2-flop synchronised.
- btn_raw  in  N_BTN  raw button pins; asynchronous.
- btn_level  out  N_BTN  debounced level; 1 = pressed.
- btn_press  out  N_BTN  1-cycle pulse on a debounced rising edge.
- btn_release  out  N_BTN  1-cycle pulse on a debounced falling edge.
- btn_long  out  N_BTN  1-cycle long-press pulse; constant 0 without the optional feature.
- sys_rst  out  1  registered, active-high reset to the core.
- led_evt  in  N_LED  event strobes, synchronous to clk.
- led  out  N_LED  stretched LED drive.

Behaviour:
- Reset (rst=1): every register clears. Reset values: btn_level/btn_press/btn_release/btn_long = 0, led = 0, sys_rst = 1, reset sequencer in WAIT_LOCK. Reset asserted mid-operation aborts any debounce or stretch immediately.
- Button path, per channel, independent:
  - Two-flop synchroniser s1→s2 (after the optional inversion).
  - Counter cnt, width $clog2(DEB_CYCLES+1).
  - Each cycle: if s2 == btn_level, cnt <= 0.
  - Otherwise cnt <= cnt+1. When cnt == DEB_CYCLES-1: btn_level <= s2, cnt <= 0, and press (s2=1) or release (s2=0) is pulsed.
  - The pulse is registered and coincides with the first cycle of the new btn_level.
  - Latency: new raw value stable from edge k gives btn_level updated at edge k+DEB_CYCLES+1, i.e. visible DEB_CYCLES+2 cycles later.
  - Any glitch back to the old level before the threshold resets cnt; no output change.
  - Counter saturates by construction; no wrap.
  - A button held through reset release produces a press DEB_CYCLES+2 cycles after rst falls.
- Reset sequencer (states WAIT_LOCK, HOLD, RUN); pll_locked below means the synchronised value:
  - WAIT_LOCK: sys_rst=1, hold counter=0. Goes to HOLD when pll_locked=1.
  - HOLD: sys_rst=1, counter increments. When counter == RST_HOLD-1, goes to RUN; sys_rst=0 from the next cycle.
  - RUN: sys_rst=0.
  - In HOLD or RUN, pll_locked=0 goes to WAIT_LOCK, sys_rst=1 on the next edge, counter cleared.
  - Lock lost and regained within HOLD restarts the full RST_HOLD count.
- LED stretcher, per channel:
  - led_evt[i]=1 loads counter with STRETCH_CYCLES-1 and sets led[i]=1 on the next edge.
  - While the counter is nonzero it decrements.
  - At 0 with no event, led[i] <= 0.
  - Retriggerable: an event during stretch reloads the counter, extending the on-time.
  - Continuous led_evt keeps led high indefinitely.
  - LEDs operate independently of sys_rst (they are cleared only by rst).

Optional Feature:
BOARD_IO_LONGPRESS_EN:
- Defined: each channel has a hold counter.
  - Counting starts at btn_press and runs while btn_level=1.
  - When it reaches LONG_CYCLES-1, btn_long pulses for exactly 1 cycle; the counter then stops until the next press.
  - Release clears it with no pulse.
- Undefined: no counter logic; btn_long tied to 0. The port remains present so the interface is stable.

Decomposition:
- Package board_io_pkg: reset-sequencer state enum {WAIT_LOCK, HOLD, RUN}, default timing constants for a 50 MHz clock, and a count-width helper function.
- Sub-module btn_debounce (single channel: synchroniser, debounce counter, edge pulses, optional long-press), instantiated N_BTN times via generate.
- Reset sequencer and LED stretcher stay inline.

Test Plan:
Bench parameters: DEB_CYCLES=4, RST_HOLD=8, STRETCH_CYCLES=6, LONG_CYCLES=20.
1. btn_raw[0] 0→1 held → btn_press[0]=1 for one cycle exactly 6 cycles after the first sampling edge; btn_level[0]=1 from that cycle. Channel 1 stays 0.
2. Bounce: btn_raw[1] high 3 cycles, low 1, high 3, then low → no btn_level/btn_press change. Then held high 4+ cycles → press fires.
3. rst released with pll_locked=0 → sys_rst stays 1. pll_locked=1 → sys_rst falls 2+8+1 cycles later. pll_locked=0 in RUN → sys_rst=1 within 3 cycles. Relock → full 8-cycle hold again.
4. led_evt[3] single pulse → led[3] high exactly 6 cycles. A second pulse at cycle 4 → total on-time 10 cycles.
5. Long press with BOARD_IO_LONGPRESS_EN: hold 30 cycles → exactly one btn_long pulse 20 cycles after btn_press. Without the macro → btn_long stays 0.
6. rst asserted mid-debounce and mid-stretch → next cycle all outputs at reset values and sys_rst=1. The held button then re-presses DEB_CYCLES+2 cycles after rst falls.
